// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared types for the CPU bus arbiter: FSM states, request bundle and access-size codes.
package cpu_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbWaitD,
    ArbWaitI
  } arb_state_e;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [3:0]  byte_enable;
    logic [31:0] wdata;
    logic [1:0]  size;
  } bus_req_t;

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// Fetch, execute and memory-side signals of the arbiter. The arbiter uses the master view;
// the surrounding pipeline and memory model use the slave view.
interface cpu_bus_arbiter_if;

  logic        cpui_request;
  logic [31:0] cpui_addr;
  logic        cpui_ack;
  logic [31:0] cpui_rdata;

  logic        cpud_request;
  logic [31:0] cpud_addr;
  logic        cpud_write;
  logic [3:0]  cpud_byte_enable;
  logic [31:0] cpud_wdata;
  logic [1:0]  cpud_size;
  logic        cpud_ack;
  logic [31:0] cpud_rdata;

  logic        mem_ready;
  logic        mem_request;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        protocol_error;

  modport master (
    input  cpui_request, cpui_addr,
    input  cpud_request, cpud_addr, cpud_write, cpud_byte_enable, cpud_wdata, cpud_size,
    input  mem_ready, mem_rvalid, mem_rdata,
    output cpui_ack, cpui_rdata, cpud_ack, cpud_rdata,
    output mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata, mem_size,
    output protocol_error
  );

  modport slave (
    output cpui_request, cpui_addr,
    output cpud_request, cpud_addr, cpud_write, cpud_byte_enable, cpud_wdata, cpud_size,
    output mem_ready, mem_rvalid, mem_rdata,
    input  cpui_ack, cpui_rdata, cpud_ack, cpud_rdata,
    input  mem_request, mem_addr, mem_write, mem_byte_enable, mem_wdata, mem_size,
    input  protocol_error
  );

endinterface

// File: rtl/cpu_bus_pending_slot.sv
// One-entry holding register for a requester's pulse. A pulse arriving while the entry is
// still held (and not cleared this cycle) is dropped and flagged as overflow.
module cpu_bus_pending_slot
  import cpu_bus_arbiter_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     capture,
  input  logic     clear,
  input  bus_req_t req,
  output logic     valid,
  output bus_req_t held,
  output logic     overflow
);

  logic     valid_q;
  bus_req_t held_q;
  logic     load;

  // Clearing and refilling in the same cycle is the legal back-to-back case.
  assign load     = capture && (!valid_q || clear);
  assign overflow = capture && valid_q && !clear;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      held_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      held_q  <= req;
    end else if (clear) begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign held  = held_q;

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction at a time.
// Define STARVE_GUARD_EN to cap consecutive data grants while a fetch is waiting.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input logic               clock,
  input logic               reset,
  cpu_bus_arbiter_if.master bus
);

  arb_state_e state_q;
  logic       perr_q;
  bus_req_t   i_req, d_req, i_held, d_held, mem_req;
  logic       i_valid, d_valid, i_ovf, d_ovf;
  logic       i_ack, d_ack, grant_i, grant_d, idle_ready, favour_i;

  always_comb begin
    i_req             = '0;
    i_req.addr        = bus.cpui_addr;
    i_req.byte_enable = 4'hF;
    i_req.size        = SizeWord;
    d_req             = '{addr: bus.cpud_addr, write: bus.cpud_write,
                          byte_enable: bus.cpud_byte_enable, wdata: bus.cpud_wdata,
                          size: bus.cpud_size};
  end

  cpu_bus_pending_slot u_slot_i (
    .clock    (clock),
    .reset    (reset),
    .capture  (bus.cpui_request),
    .clear    (i_ack),
    .req      (i_req),
    .valid    (i_valid),
    .held     (i_held),
    .overflow (i_ovf)
  );

  cpu_bus_pending_slot u_slot_d (
    .clock    (clock),
    .reset    (reset),
    .capture  (bus.cpud_request),
    .clear    (d_ack),
    .req      (d_req),
    .valid    (d_valid),
    .held     (d_held),
    .overflow (d_ovf)
  );

  // Responses arriving in IDLE (e.g. late after a reset) are ignored.
  assign i_ack      = !reset && (state_q == ArbWaitI) && bus.mem_rvalid;
  assign d_ack      = !reset && (state_q == ArbWaitD) && bus.mem_rvalid;
  assign idle_ready = !reset && (state_q == ArbIdle) && bus.mem_ready;
  assign grant_i    = idle_ready && i_valid && (!d_valid || favour_i);
  assign grant_d    = idle_ready && d_valid && !grant_i;

`ifdef STARVE_GUARD_EN
  logic [2:0] streak_q;

  assign favour_i = (streak_q == 3'(MAX_DATA_STREAK));

  always_ff @(posedge clock) begin
    if (reset || !i_valid || grant_i) begin
      streak_q <= '0;
    end else if (grant_d && (streak_q != 3'd7)) begin
      streak_q <= streak_q + 3'd1;
    end
  end
`else
  logic unused_max_streak;

  assign favour_i          = 1'b0;
  assign unused_max_streak = ^MAX_DATA_STREAK;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ArbIdle;
      perr_q  <= 1'b0;
    end else begin
      perr_q <= perr_q | i_ovf | d_ovf;
      unique case (state_q)
        ArbIdle: begin
          if (grant_d) begin
            state_q <= ArbWaitD;
          end else if (grant_i) begin
            state_q <= ArbWaitI;
          end
        end
        ArbWaitD, ArbWaitI: begin
          if (bus.mem_rvalid) begin
            state_q <= ArbIdle;
          end
        end
        default: state_q <= ArbIdle;
      endcase
    end
  end

  assign mem_req             = grant_i ? i_held : (grant_d ? d_held : '0);
  assign bus.mem_request     = grant_i | grant_d;
  assign bus.mem_addr        = mem_req.addr;
  assign bus.mem_write       = mem_req.write;
  assign bus.mem_byte_enable = mem_req.byte_enable;
  assign bus.mem_wdata       = mem_req.wdata;
  assign bus.mem_size        = mem_req.size;

  assign bus.cpui_ack        = i_ack;
  assign bus.cpui_rdata      = i_ack ? bus.mem_rdata : '0;
  assign bus.cpud_ack        = d_ack;
  assign bus.cpud_rdata      = d_ack ? bus.mem_rdata : '0;
  assign bus.protocol_error  = perr_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: directed scenarios then random traffic, all checked against a
// transaction-level model of pending requests, the single outstanding access and the error flag.
module tb_cpu_bus_arbiter;
  import cpu_bus_arbiter_pkg::*;

  localparam int unsigned MaxStreak = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cpu_bus_arbiter_if bus ();

  cpu_bus_arbiter #(.MAX_DATA_STREAK(MaxStreak)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: index 0 = fetch port, 1 = data port.
  bit       m_pend [2];
  bus_req_t m_req  [2];
  bit       m_busy   = 1'b0;
  int       m_owner  = 0;
  bit       m_perr   = 1'b0;
  int       m_streak = 0;
  int       m_grant  = -1;
  bit       e_iack, e_dack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic predict();
    bit favour;
    e_iack  = m_busy && (m_owner == 0) && bus.mem_rvalid;
    e_dack  = m_busy && (m_owner == 1) && bus.mem_rvalid;
    m_grant = -1;
    if (!m_busy && bus.mem_ready && (m_pend[0] || m_pend[1])) begin
      favour = 1'b0;
`ifdef STARVE_GUARD_EN
      favour = (m_streak == int'(MaxStreak));
`endif
      m_grant = (m_pend[1] && !(m_pend[0] && favour)) ? 1 : 0;
    end
  endtask

  task automatic compare_model();
    chk("mem_request", bus.mem_request, m_grant >= 0);
    if (m_grant >= 0) begin
      chk("mem_addr", bus.mem_addr, m_req[m_grant].addr);
      if (m_grant == 1) begin
        chk("mem_write", bus.mem_write, m_req[1].write);
        chk("mem_be", bus.mem_byte_enable, m_req[1].byte_enable);
        chk("mem_wdata", bus.mem_wdata, m_req[1].wdata);
        chk("mem_size", bus.mem_size, m_req[1].size);
      end else begin
        chk("mem_write_i", bus.mem_write, 0);
        chk("mem_be_i", bus.mem_byte_enable, 4'hF);
        chk("mem_size_i", bus.mem_size, 2'b10);
      end
    end
    chk("cpui_ack", bus.cpui_ack, e_iack);
    chk("cpud_ack", bus.cpud_ack, e_dack);
    if (e_iack) chk("cpui_rdata", bus.cpui_rdata, bus.mem_rdata);
    if (e_dack) chk("cpud_rdata", bus.cpud_rdata, bus.mem_rdata);
    chk("protocol_error", bus.protocol_error, m_perr);
  endtask

  task automatic advance();
    if (reset) begin
      m_pend[0] = 1'b0;
      m_pend[1] = 1'b0;
      m_busy    = 1'b0;
      m_perr    = 1'b0;
      m_streak  = 0;
      return;
    end
    if (!m_pend[0] || m_grant == 0) m_streak = 0;
    else if (m_grant == 1 && m_streak < 7) m_streak++;
    if (e_iack) begin m_pend[0] = 1'b0; m_busy = 1'b0; end
    if (e_dack) begin m_pend[1] = 1'b0; m_busy = 1'b0; end
    if (m_grant >= 0) begin m_busy = 1'b1; m_owner = m_grant; end
    if (bus.cpui_request) begin
      if (m_pend[0]) m_perr = 1'b1;
      else begin m_pend[0] = 1'b1; m_req[0] = '0; m_req[0].addr = bus.cpui_addr; end
    end
    if (bus.cpud_request) begin
      if (m_pend[1]) m_perr = 1'b1;
      else begin
        m_pend[1] = 1'b1;
        m_req[1]  = '{addr: bus.cpud_addr, write: bus.cpud_write,
                      byte_enable: bus.cpud_byte_enable, wdata: bus.cpud_wdata,
                      size: bus.cpud_size};
      end
    end
  endtask

  // One clock: check at the falling edge, update the model at the rising edge, drop pulses.
  task automatic tick();
    @(negedge clock);
    predict();
    if (!reset) compare_model();
    @(posedge clock);
    advance();
    cyc++;
    #1;
    bus.cpui_request = 1'b0;
    bus.cpud_request = 1'b0;
    bus.mem_rvalid   = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ireq"}, bus.mem_request, 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_wr"}, bus.mem_write, 0);
    chk({tag, "_be"}, bus.mem_byte_enable, 0);
    chk({tag, "_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_size"}, bus.mem_size, 0);
    chk({tag, "_iack"}, bus.cpui_ack, 0);
    chk({tag, "_irdata"}, bus.cpui_rdata, 0);
    chk({tag, "_dack"}, bus.cpud_ack, 0);
    chk({tag, "_drdata"}, bus.cpud_rdata, 0);
    chk({tag, "_perr"}, bus.protocol_error, 0);
  endtask

  task automatic data_req(input logic [31:0] a, input logic w, input logic [3:0] be,
                          input logic [31:0] wd, input logic [1:0] sz);
    bus.cpud_request     = 1'b1;
    bus.cpud_addr        = a;
    bus.cpud_write       = w;
    bus.cpud_byte_enable = be;
    bus.cpud_wdata       = wd;
    bus.cpud_size        = sz;
  endtask

  initial begin
    int dg, issued, acks, bad_addr;
    bit ig, pend_resp, last_i, done;

    reset = 1'b1;
    bus.cpui_request = 1'b0; bus.cpui_addr = '0;
    data_req(32'h0, 1'b0, 4'h0, 32'h0, 2'b00);
    bus.cpud_request = 1'b0;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    reset = 1'b0;
    #1 chk_zero("reset");

    // Single read.
    bus.mem_ready = 1'b1;
    data_req(32'h100, 1'b0, 4'hF, 32'h0, SizeWord);
    tick();
    chk("rd_mreq", bus.mem_request, 1);
    chk("rd_maddr", bus.mem_addr, 32'h100);
    tick(); tick();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_dack", bus.cpud_ack, 1);
    chk("rd_drdata", bus.cpud_rdata, 32'hDEAD_BEEF);
    chk("rd_iack", bus.cpui_ack, 0);
    tick();

    // Simultaneous fetch and data write: data first, fetch the cycle after the data ack.
    bus.cpui_request = 1'b1; bus.cpui_addr = 32'h40;
    data_req(32'h200, 1'b1, 4'b0100, 32'h00AB_0000, SizeByte);
    tick();
    chk("sim_daddr", bus.mem_addr, 32'h200);
    chk("sim_dwr", bus.mem_write, 1);
    tick(); tick();
    bus.mem_rvalid = 1'b1;
    #1 chk("sim_nogrant_at_ack", bus.mem_request, 0);
    tick();
    chk("sim_ireq", bus.mem_request, 1);
    chk("sim_iaddr", bus.mem_addr, 32'h40);
    tick();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1357_9BDF;
    #1 chk("sim_iack", bus.cpui_ack, 1);
    tick();

    // mem_ready low holds the request back.
    bus.mem_ready = 1'b0;
    data_req(32'h300, 1'b0, 4'hF, 32'h0, SizeWord);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("rdy_hold", bus.mem_request, 0);
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("rdy_issue", bus.mem_request, 1);
    chk("rdy_addr", bus.mem_addr, 32'h300);
    tick();
    bus.mem_rvalid = 1'b1;
    tick();

    // Second data pulse while pending: dropped, flagged, single ack.
    bus.mem_ready = 1'b0;
    data_req(32'h400, 1'b0, 4'hF, 32'h0, SizeWord);
    tick();
    data_req(32'h500, 1'b1, 4'hF, 32'h5555_5555, SizeWord);
    tick();
    chk("perr_set", bus.protocol_error, 1);
    bus.mem_ready = 1'b1;
    #1 chk("perr_orig_addr", bus.mem_addr, 32'h400);
    acks = 0; bad_addr = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) bus.mem_rvalid = 1'b1;
      #1;
      if (bus.cpud_ack) acks++;
      if (bus.mem_request && bus.mem_addr == 32'h500) bad_addr++;
      tick();
    end
    chk("perr_one_ack", acks, 1);
    chk("perr_no_drop_issue", bad_addr, 0);
    chk("perr_sticky", bus.protocol_error, 1);

    // Reset while waiting for data, followed by a stray response.
    data_req(32'h600, 1'b0, 4'hF, 32'h0, SizeWord);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
    #1 chk_zero("rst_wait");
    tick();
    data_req(32'h700, 1'b0, 4'hF, 32'h0, SizeWord);
    tick();
    chk("rst_fresh_req", bus.mem_request, 1);
    chk("rst_fresh_addr", bus.mem_addr, 32'h700);
    tick();
    bus.mem_rvalid = 1'b1;
    #1 chk("rst_fresh_ack", bus.cpud_ack, 1);
    tick();

    // Fetch waiting behind back-to-back data requests.
    bus.cpui_request = 1'b1; bus.cpui_addr = 32'h80;
    data_req(32'h900, 1'b0, 4'hF, 32'h0, SizeWord);
    tick();
    dg = 0; issued = 1; ig = 1'b0; pend_resp = 1'b0; last_i = 1'b0; done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      if (pend_resp) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'(k);
        if (last_i) done = 1'b1;
        else if (issued < 6) begin
          data_req(32'h900 + 32'(issued) * 4, 1'b0, 4'hF, 32'h0, SizeWord);
          issued++;
        end
        pend_resp = 1'b0;
      end else if (bus.mem_request) begin
        pend_resp = 1'b1;
        last_i    = (bus.mem_addr == 32'h80);
        if (last_i) ig = 1'b1;
        else dg++;
      end
      tick();
    end
    chk("starve_fetch_granted", ig, 1);
`ifdef STARVE_GUARD_EN
    chk("starve_data_grants", dg, MaxStreak);
`else
    chk("starve_data_grants", dg, 6);
`endif

    // Random traffic.
    for (int k = 0; k < 2000; k++) begin
      reset = ($urandom_range(0, 299) == 0);
      bus.mem_ready = ($urandom_range(0, 3) != 0);
      bus.mem_rvalid = m_busy ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
      bus.mem_rdata = $urandom;
      if ($urandom_range(0, 9) < 2) begin
        bus.cpui_request = 1'b1;
        bus.cpui_addr    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      end
      if ($urandom_range(0, 9) < 3) begin
        data_req($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                 2'($urandom_range(0, 2)));
      end
      tick();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
